switch_input_port: RTL and testbench
====================================

Name: switch_input_port

Overview:
- Input-side companion to the LED output port on the Nios II system.
- Takes raw board switches and keys asynchronous to iCLK_50, then synchronises and debounces them.
- Latches edges and exposes everything to the CPU as an Avalon-MM slave with a level interrupt.
- Also drives the debounced levels out directly, so fabric logic (e.g. the 7-segment counter) can share the clean signals.

Parameters:
- WIDTH, 10, number of input bits (1..32).
- DEBOUNCE_CYCLES, 500000, consecutive stable samples needed to accept a change (10 ms at 50 MHz); minimum 2.
- EDGE_TYPE, 0, edge that sets a capture bit: 0 rising, 1 falling, 2 both.

Ports:
- iCLK_50  in  1  system clock, 50 MHz.
- iRST  in  1  synchronous reset, active-high.
- iSW  in  WIDTH  raw asynchronous switch/key inputs.
- iADDRESS  in  2  Avalon word address.
- iREAD  in  1  Avalon read strobe.
- iWRITE  in  1  Avalon write strobe.
- iWRITEDATA  in  32  Avalon write data.
- oREADDATA  out  32  Avalon read data, registered.
- oIRQ  out  1  interrupt request, level, active-high.
- oLEVEL  out  WIDTH  debounced input levels.

Behaviour:
- Clock and reset: one clock, iCLK_50. Reset is synchronous and active-high on iRST. All state updates on the rising edge.
- Reset values:
  - sync stages, stable register and counters cleared to 0; oLEVEL = 0.
  - edgecapture = 0, irqmask = 0, oREADDATA = 0, oIRQ = 0.
- Synchroniser: two flops per bit, sync1 then sync2. No logic between the two stages.
- Debounce, per bit, independent counter of width clog2(DEBOUNCE_CYCLES):
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter <= 0.
  - A single-cycle glitch back to stable resets the counter.
  - Latency: input settled before edge k gives oLEVEL change after edge k+DEBOUNCE_CYCLES+1.
- oLEVEL = stable, driven straight from the register.
- Edge capture:
  - On the edge where stable[i] updates, edgecapture[i] <= 1 if the transition matches EDGE_TYPE.
  - Bits are sticky until cleared.
- Register map (32-bit words; unused upper bits read 0):
  - 0 DATA, RO: stable levels.
  - 1 IRQMASK, RW: bits [WIDTH-1:0].
  - 2 EDGECAPTURE, R/W1C: writing 1 clears the bit, writing 0 has no effect.
  - 3 RAW, RO: sync2 levels.
- Writes to RO addresses are ignored.
- Reads:
  - oREADDATA is updated on the edge where iREAD is sampled high; fixed read latency of 1 cycle, no waitrequest.
  - When iREAD is low, oREADDATA holds its last value.
- Simultaneous W1C clear and a new matching edge on the same bit in the same cycle: the set wins and the bit stays 1.
- oIRQ = |(edgecapture & irqmask), combinational from registers.
  - oIRQ asserts in the same cycle the capture bit becomes visible.
  - oIRQ deasserts the cycle after a clear or unmask takes effect.
- Simultaneous iREAD and iWRITE: both are performed. Read data reflects register contents before the write.
- Reset mid-debounce: the pending change is discarded. After reset, an input held at 1 gets re-accepted as a rising edge after DEBOUNCE_CYCLES+2 cycles.

Optional Feature:
- Macro: SWITCH_INPUT_PORT_DEBOUNCE_EN.
- Defined: debounce logic as described above.
- Not defined:
  - Counters are not instantiated; stable <= sync2 every cycle.
  - Latency is 3 cycles from input to oLEVEL; DEBOUNCE_CYCLES is ignored.
  - Register map, edge capture and IRQ behaviour are unchanged.

Test Plan:
- Reset (bench DEBOUNCE_CYCLES=4, WIDTH=10, EDGE_TYPE=0): drive iSW=10'h3FF during iRST -> oLEVEL=0, oIRQ=0, all register reads 0. Release reset -> oLEVEL=10'h3FF after 6 cycles, EDGECAPTURE=10'h3FF.
- Glitch rejection: iSW[0] high for 3 cycles then low -> oLEVEL[0] stays 0, EDGECAPTURE bit 0 stays 0. Held high for 4+ cycles -> oLEVEL[0]=1, 6 cycles after the rise.
- IRQ flow: write IRQMASK=0x004, raise iSW[2] -> oIRQ=1 in the cycle EDGECAPTURE[2] sets. Write EDGECAPTURE=0x004 -> oIRQ=0 the next cycle. Raise iSW[3] with mask 0 -> no IRQ.
- Clear/set collision: W1C of bit 5 lands on the same edge stable[5] rises -> EDGECAPTURE reads 0x020 afterwards.
- Read timing: read address 3 with iSW=10'h155 settled -> oREADDATA=0x155 one cycle after iREAD, while DATA still shows the previous value during the debounce window.
- Macro off: iSW[1] 1-cycle pulse -> oLEVEL[1] pulses for 1 cycle, 3 cycles later. EDGECAPTURE bit 1 sets.

Source files
------------

// File: rtl/switch_input_port.sv
// Switch/key input port: two-flop synchroniser, per-bit debounce, edge capture and an Avalon-MM slave with a level IRQ.
// Debounce counters exist only when SWITCH_INPUT_PORT_DEBOUNCE_EN is defined; otherwise the synchronised input is taken every cycle.
module switch_input_port #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             iCLK_50,
    input  logic             iRST,
    input  logic [WIDTH-1:0] iSW,
    input  logic [1:0]       iADDRESS,
    input  logic             iREAD,
    input  logic             iWRITE,
    input  logic [31:0]      iWRITEDATA,
    output logic [31:0]      oREADDATA,
    output logic             oIRQ,
    output logic [WIDTH-1:0] oLEVEL
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stableNext;
    logic [WIDTH-1:0] edgeCapture;
    logic [WIDTH-1:0] irqMask;
    logic [WIDTH-1:0] riseEv;
    logic [WIDTH-1:0] fallEv;
    logic [WIDTH-1:0] setMask;
    logic [WIDTH-1:0] clearMask;
    logic [31:0]      readMux;
    logic             unusedWriteBits;

`ifdef SWITCH_INPUT_PORT_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] count     [WIDTH];
    logic [CW-1:0] countNext [WIDTH];

    // A sample equal to the accepted level restarts the count, so glitches never accumulate.
    always_comb begin
        stableNext = stable;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            countNext[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (count[i] == CMAX) begin
                    stableNext[i] = sync2[i];
                end else begin
                    countNext[i] = count[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                count[i] <= '0;
            end
        end else begin
            count <= countNext;
        end
    end
`else
    localparam int unusedDebounceCycles = DEBOUNCE_CYCLES;

    always_comb begin
        stableNext = sync2;
    end
`endif

    always_comb begin
        riseEv = stableNext & ~stable;
        fallEv = ~stableNext & stable;
        case (EDGE_TYPE)
            0:       setMask = riseEv;
            1:       setMask = fallEv;
            default: setMask = riseEv | fallEv;
        endcase
    end

    always_comb begin
        clearMask = '0;
        if (iWRITE && iADDRESS == 2'd2) begin
            clearMask = iWRITEDATA[WIDTH-1:0];
        end
    end

    always_comb begin
        readMux = '0;
        case (iADDRESS)
            2'd0: readMux[WIDTH-1:0] = stable;
            2'd1: readMux[WIDTH-1:0] = irqMask;
            2'd2: readMux[WIDTH-1:0] = edgeCapture;
            default: readMux[WIDTH-1:0] = sync2;
        endcase
    end

    assign unusedWriteBits = ^iWRITEDATA;

    always_ff @(posedge iCLK_50) begin
        if (iRST) begin
            sync1       <= '0;
            sync2       <= '0;
            stable      <= '0;
            edgeCapture <= '0;
            irqMask     <= '0;
            oREADDATA   <= '0;
        end else begin
            sync1  <= iSW;
            sync2  <= sync1;
            stable <= stableNext;
            // Set is OR-ed after the clear so a fresh edge survives a same-cycle W1C.
            edgeCapture <= (edgeCapture & ~clearMask) | setMask;
            if (iWRITE && iADDRESS == 2'd1) begin
                irqMask <= iWRITEDATA[WIDTH-1:0];
            end
            if (iREAD) begin
                oREADDATA <= readMux;
            end
        end
    end

    assign oIRQ   = |(edgeCapture & irqMask);
    assign oLEVEL = stable;

endmodule

// File: tb/tb_switch_input_port.sv
// Scoreboard bench for switch_input_port: directed scenarios, then randomized traffic against a sample-history reference model.
// Follows SWITCH_INPUT_PORT_DEBOUNCE_EN the same way the design does.
module tb_switch_input_port;

    localparam int W  = 10;
    localparam int D  = 4;
    localparam int ET = 0;
`ifdef SWITCH_INPUT_PORT_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
    localparam int LAT = D + 1;
`else
    localparam bit DEB = 1'b0;
    localparam int LAT = 2;
`endif

    logic          iCLK_50 = 1'b0;
    logic          iRST = 1'b1;
    logic [W-1:0]  iSW = '0;
    logic [1:0]    iADDRESS = '0;
    logic          iREAD = 1'b0;
    logic          iWRITE = 1'b0;
    logic [31:0]   iWRITEDATA = '0;
    logic [31:0]   oREADDATA;
    logic          oIRQ;
    logic [W-1:0]  oLEVEL;

    int checks = 0;
    int failures = 0;

    switch_input_port #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .EDGE_TYPE(ET)
    ) dut (
        .iCLK_50(iCLK_50),
        .iRST(iRST),
        .iSW(iSW),
        .iADDRESS(iADDRESS),
        .iREAD(iREAD),
        .iWRITE(iWRITE),
        .iWRITEDATA(iWRITEDATA),
        .oREADDATA(oREADDATA),
        .oIRQ(oIRQ),
        .oLEVEL(oLEVEL)
    );

    always #5 iCLK_50 = ~iCLK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once D consecutive synchronised samples all disagree with it.
    logic [W-1:0] mS1 = '0, mS2 = '0, mStable = '0, mEdge = '0, mMask = '0;
    logic [W-1:0] hist[$];
    logic [31:0]  expQ[$];
    bit           rdPend = 1'b0;

    always @(posedge iCLK_50) begin : modelProc
        logic [W-1:0] nStable, rise, fall, setM, clrM;
        logic [31:0]  rd;
        bit           allDiff;
        rdPend = iREAD;
        if (iRST) begin
            if (iREAD) expQ.push_back(32'h0);
            mS1 = '0; mS2 = '0; mStable = '0; mEdge = '0; mMask = '0;
            hist.delete();
        end else begin
            if (iREAD) begin
                rd = '0;
                case (iADDRESS)
                    2'd0: rd[W-1:0] = mStable;
                    2'd1: rd[W-1:0] = mMask;
                    2'd2: rd[W-1:0] = mEdge;
                    default: rd[W-1:0] = mS2;
                endcase
                expQ.push_back(rd);
            end
            hist.push_back(mS2);
            if (hist.size() > D) void'(hist.pop_front());
            if (DEB) begin
                nStable = mStable;
                if (hist.size() == D) begin
                    for (int i = 0; i < W; i++) begin
                        allDiff = 1'b1;
                        foreach (hist[j]) if (hist[j][i] == mStable[i]) allDiff = 1'b0;
                        if (allDiff) nStable[i] = ~mStable[i];
                    end
                end
            end else begin
                nStable = mS2;
            end
            rise = nStable & ~mStable;
            fall = mStable & ~nStable;
            setM = (ET == 0) ? rise : (ET == 1) ? fall : (rise | fall);
            clrM = (iWRITE && iADDRESS == 2'd2) ? iWRITEDATA[W-1:0] : '0;
            mEdge = (mEdge & ~clrM) | setM;
            if (iWRITE && iADDRESS == 2'd1) mMask = iWRITEDATA[W-1:0];
            mStable = nStable;
            mS2 = mS1;
            mS1 = iSW;
        end
    end

    always @(negedge iCLK_50) begin : monitorProc
        check("oLEVEL", 32'(oLEVEL), 32'(mStable));
        check("oIRQ", 32'(oIRQ), 32'(|(mEdge & mMask)));
        if (rdPend) begin
            if (expQ.size() == 0) begin
                check("readQueueEmpty", 32'h1, 32'h0);
            end else begin
                check("oREADDATA", oREADDATA, expQ.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge iCLK_50);
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        iWRITE = 1'b1; iADDRESS = a; iWRITEDATA = d;
        tick(1);
        iWRITE = 1'b0;
    endtask

    task automatic busRead(input logic [1:0] a, output logic [31:0] v);
        iREAD = 1'b1; iADDRESS = a;
        tick(1);
        iREAD = 1'b0;
        v = oREADDATA;
    endtask

    initial begin : stimProc
        logic [31:0] v;
        iRST = 1'b1;
        iSW = 10'h3FF;
        tick(3);
        check("resetLevel", 32'(oLEVEL), 32'h0);
        check("resetIrq", 32'(oIRQ), 32'h0);
        for (int a = 0; a < 4; a++) begin
            busRead(2'(a), v);
            check("resetRead", v, 32'h0);
        end
        iRST = 1'b0;
        tick(LAT + 5);
        check("postResetLevel", 32'(oLEVEL), 32'h3FF);
        busRead(2'd2, v);
        check("postResetEdges", v, 32'h3FF);
        busWrite(2'd2, 32'h3FF);
        iSW = '0;
        tick(LAT + 4);

        if (DEB) begin
            iSW[0] = 1'b1;
            tick(3);
            iSW[0] = 1'b0;
            tick(LAT + 4);
            check("glitchLevel", 32'(oLEVEL[0]), 32'h0);
            busRead(2'd2, v);
            check("glitchEdge", v, 32'h0);
        end else begin
            iSW[1] = 1'b1;
            tick(1);
            iSW[1] = 1'b0;
            tick(LAT + 3);
            busRead(2'd2, v);
            check("pulseEdge", v, 32'h2);
        end
        iSW[0] = 1'b1;
        tick(LAT);
        check("riseBeforeAccept", 32'(oLEVEL[0]), 32'h0);
        tick(1);
        check("riseAccepted", 32'(oLEVEL[0]), 32'h1);
        iSW = '0;
        tick(LAT + 4);
        busWrite(2'd2, 32'h3FF);

        busWrite(2'd1, 32'h004);
        iSW[2] = 1'b1;
        tick(LAT);
        check("irqBeforeEdge", 32'(oIRQ), 32'h0);
        tick(1);
        check("irqOnEdge", 32'(oIRQ), 32'h1);
        busWrite(2'd2, 32'h004);
        check("irqAfterClear", 32'(oIRQ), 32'h0);
        busWrite(2'd1, 32'h000);
        iSW[3] = 1'b1;
        tick(LAT + 3);
        check("irqMasked", 32'(oIRQ), 32'h0);
        busRead(2'd2, v);
        check("maskedEdge", v, 32'h008);

        busWrite(2'd2, 32'h3FF);
        iSW[5] = 1'b1;
        tick(LAT);
        busWrite(2'd2, 32'h020);
        busRead(2'd2, v);
        check("collisionSetWins", v, 32'h020);

        busWrite(2'd2, 32'h3FF);
        iSW = 10'h155;
        tick(2);
        busRead(2'd3, v);
        check("rawRead", v, 32'h155);
        busRead(2'd0, v);
        if (DEB) check("dataDuringDebounce", v, 32'h02C);
        tick(LAT + 4);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5) == 0) iSW[$urandom_range(W - 1)] ^= 1'b1;
            if ($urandom_range(99) == 0) iSW = W'($urandom);
            iRST = ($urandom_range(399) == 0);
            iREAD = ($urandom_range(2) == 0);
            iWRITE = ($urandom_range(3) == 0);
            iADDRESS = 2'($urandom);
            iWRITEDATA = $urandom;
            tick(1);
        end
        iRST = 1'b0; iREAD = 1'b0; iWRITE = 1'b0;
        tick(LAT + 5);
        check("queueDrained", 32'(expQ.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
